// File: rtl/clock_pkg.sv
// ----------------------------------------------------------------------------
// Module  : clock_pkg
// Purpose : Shared types, limits and field encodings for the time-set
//           controller, plus small wrap-around helpers for the edit fields.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

package clock_pkg;

  // Controller states; explicit 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SET_HR  = 3'd1,
    ST_SET_MIN = 3'd2,
    ST_SET_SEC = 3'd3,
    ST_SET_AP  = 3'd4,
    ST_LOAD    = 3'd5
  } state_t;

  localparam logic [4:0] HOUR_MAX   = 5'd12;
  localparam logic [4:0] HOUR_MIN   = 5'd1;
  localparam logic [5:0] MINSEC_MAX = 6'd59;

  // field_sel encodings
  localparam logic [1:0] FIELD_HR  = 2'd0;
  localparam logic [1:0] FIELD_MIN = 2'd1;
  localparam logic [1:0] FIELD_SEC = 2'd2;
  localparam logic [1:0] FIELD_AP  = 2'd3;

  // Hours live in 1..12; anything at or above 12 wraps to 1.
  function automatic logic [4:0] hour_inc(input logic [4:0] h);
    return (h >= HOUR_MAX) ? HOUR_MIN : h + 5'd1;
  endfunction

  function automatic logic [4:0] hour_dec(input logic [4:0] h);
    return (h <= HOUR_MIN) ? HOUR_MAX : h - 5'd1;
  endfunction

  function automatic logic [5:0] minsec_inc(input logic [5:0] v);
    return (v >= MINSEC_MAX) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] minsec_dec(input logic [5:0] v);
    return (v == 6'd0) ? MINSEC_MAX : v - 6'd1;
  endfunction

  // The live counter may present out-of-range values; force them legal
  // so the edit arithmetic never starts from an illegal value.
  function automatic logic [4:0] sanitize_hour(input logic [4:0] h);
    return ((h == 5'd0) || (h > HOUR_MAX)) ? HOUR_MAX : h;
  endfunction

  function automatic logic [5:0] sanitize_minsec(input logic [5:0] v);
    return (v > MINSEC_MAX) ? 6'd0 : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/time_set_ctrl_if.sv
// ----------------------------------------------------------------------------
// Module  : time_set_ctrl_if
// Purpose : Bundle between the time-set controller and the 12-hour counter.
// Ports   : cur_hours/cur_mins/cur_secs/cur_ap  live time from the counter
//           hours_o/mins_o/secs_o/A_P_o          edit values to counter load
//           start      one-cycle load strobe
//           setting    high while editing
//           field_sel  field being edited (0=hr,1=min,2=sec,3=AM/PM)
//           modport master = controller side, slave = counter side
// Rev     : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface time_set_ctrl_if;
  logic [4:0] cur_hours;
  logic [5:0] cur_mins;
  logic [5:0] cur_secs;
  logic       cur_ap;
  logic [4:0] hours_o;
  logic [5:0] mins_o;
  logic [5:0] secs_o;
  logic       A_P_o;
  logic       start;
  logic       setting;
  logic [1:0] field_sel;

  modport master (
    input  cur_hours, cur_mins, cur_secs, cur_ap,
    output hours_o, mins_o, secs_o, A_P_o, start, setting, field_sel
  );

  modport slave (
    output cur_hours, cur_mins, cur_secs, cur_ap,
    input  hours_o, mins_o, secs_o, A_P_o, start, setting, field_sel
  );
endinterface

`default_nettype wire

// File: rtl/btn_edge.sv
// ----------------------------------------------------------------------------
// Module  : btn_edge
// Purpose : Synchronizes one asynchronous button and emits a single-cycle
//           pulse on its rising edge. SYNC_STAGES is legal in 2..3.
// Ports   : clk, reset (sync, active-high), i_btn (async), o_pulse
// Rev     : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module btn_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic i_btn,
  output logic      o_pulse
);

  // Pulses are held off until the chain has refilled with real input and
  // the edge flop has seen it once, so a button already down at reset
  // release never looks like a fresh press.
  localparam int                FILL_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [FILL_W-1:0]      r_fill;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_fill <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
      r_prev <= r_sync[SYNC_STAGES-1];
      if (r_fill != FILL_DONE) r_fill <= r_fill + 1'b1;
    end
  end

  assign o_pulse = r_sync[SYNC_STAGES-1] & ~r_prev & (r_fill == FILL_DONE);

endmodule

`default_nettype wire

// File: rtl/time_set_ctrl.sv
// ----------------------------------------------------------------------------
// Module  : time_set_ctrl
// Purpose : Button-driven time-set controller for a 12-hour clock. Mode
//           enters edit and steps hour->min->sec->AM/PM->load; inc/dec
//           adjust the selected field with per-field wrap and no carry.
// Ports   : clk, reset (sync, active-high), btn_mode, btn_inc,
//           btn_dec (only with BTN_DEC_EN), bus (time_set_ctrl_if.master)
// Config  : BTN_DEC_EN  defined -> decrement button and logic present
//                       undefined -> increment-only editing
// Rev     : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic         btn_mode,
  input  wire logic         btn_inc,
`ifdef BTN_DEC_EN
  input  wire logic         btn_dec,
`endif
  time_set_ctrl_if.master   bus
);

  logic   w_mode_p;
  logic   w_inc_p;
  logic   w_dec_p;
  logic   w_edit;
  state_t r_state;
  state_t w_next;

  logic [4:0] r_hours;
  logic [5:0] r_mins;
  logic [5:0] r_secs;
  logic       r_ap;

  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mode (
    .clk(clk), .reset(reset), .i_btn(btn_mode), .o_pulse(w_mode_p)
  );

  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_inc (
    .clk(clk), .reset(reset), .i_btn(btn_inc), .o_pulse(w_inc_p)
  );

`ifdef BTN_DEC_EN
  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_dec (
    .clk(clk), .reset(reset), .i_btn(btn_dec), .o_pulse(w_dec_p)
  );
`else
  assign w_dec_p = 1'b0;
`endif

  // Mode has priority; simultaneous inc and dec cancel each other.
  assign w_edit = ~w_mode_p & (w_inc_p ^ w_dec_p);

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:    if (w_mode_p) w_next = ST_SET_HR;
      ST_SET_HR:  if (w_mode_p) w_next = ST_SET_MIN;
      ST_SET_MIN: if (w_mode_p) w_next = ST_SET_SEC;
      ST_SET_SEC: if (w_mode_p) w_next = ST_SET_AP;
      ST_SET_AP:  if (w_mode_p) w_next = ST_LOAD;
      ST_LOAD:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.start     = 1'b0;
    bus.setting   = 1'b0;
    bus.field_sel = FIELD_HR;
    unique case (r_state)
      ST_SET_HR:  begin bus.setting = 1'b1; bus.field_sel = FIELD_HR;  end
      ST_SET_MIN: begin bus.setting = 1'b1; bus.field_sel = FIELD_MIN; end
      ST_SET_SEC: begin bus.setting = 1'b1; bus.field_sel = FIELD_SEC; end
      ST_SET_AP:  begin bus.setting = 1'b1; bus.field_sel = FIELD_AP;  end
      ST_LOAD:    bus.start = 1'b1;
      default:    ;
    endcase
  end

  // Edit registers: capture on entry, adjust while editing, otherwise hold
  // (which keeps them stable through LOAD and in IDLE).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hours <= HOUR_MIN;
      r_mins  <= 6'd0;
      r_secs  <= 6'd0;
      r_ap    <= 1'b0;
    end else if ((r_state == ST_IDLE) && w_mode_p) begin
      r_hours <= sanitize_hour(bus.cur_hours);
      r_mins  <= sanitize_minsec(bus.cur_mins);
      r_secs  <= sanitize_minsec(bus.cur_secs);
      r_ap    <= bus.cur_ap;
    end else if (w_edit) begin
      case (r_state)
        ST_SET_HR:  r_hours <= w_inc_p ? hour_inc(r_hours) : hour_dec(r_hours);
        ST_SET_MIN: r_mins  <= w_inc_p ? minsec_inc(r_mins) : minsec_dec(r_mins);
        ST_SET_SEC: r_secs  <= w_inc_p ? minsec_inc(r_secs) : minsec_dec(r_secs);
        ST_SET_AP:  r_ap    <= ~r_ap;
        default:    ;
      endcase
    end
  end

  assign bus.hours_o = r_hours;
  assign bus.mins_o  = r_mins;
  assign bus.secs_o  = r_secs;
  assign bus.A_P_o   = r_ap;

endmodule

`default_nettype wire
